led_sweep_ctrl: RTL and testbench

LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

---
 rtl/led_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_led_sweep_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: triangle sweep of an 8-bit LED value between 0 and a
// captured limit, stepped by a prescaled tick, with dwell holds at both ends,
// optional auto-stop after CYCLES sweeps, and abort via stop.
module led_sweep_ctrl #(
    parameter int unsigned DIV    = 4194304,
    parameter int unsigned DWELL  = 4,
    parameter int unsigned CYCLES = 0
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] limit,
    output logic [7:0] led,
    output logic       busy,
    output logic       dir,
    output logic       done
);

    localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
    localparam logic [7:0]    DWELL_MAX = 8'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        HOLD_TOP = 3'd2,
        DOWN     = 3'd3,
        HOLD_BOT = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [7:0]    dwell_cnt, dwell_nx;
    logic [31:0]   sweep_cnt, sweep_nx;
    logic [7:0]    lim_q, lim_nx;
    logic [7:0]    led_nx;
    logic          busy_nx, dir_nx, done_nx;
    logic          tick;

    assign tick = (presc == PRE_MAX);

    // State and all outputs registered; srst clears everything and beats start/stop.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            presc     <= '0;
            dwell_cnt <= '0;
            sweep_cnt <= '0;
            lim_q     <= '0;
            led       <= '0;
            busy      <= 1'b0;
            dir       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            dwell_cnt <= dwell_nx;
            sweep_cnt <= sweep_nx;
            lim_q     <= lim_nx;
            led       <= led_nx;
            busy      <= busy_nx;
            dir       <= dir_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-output logic; outputs derive from the next state so
    // the registered copies always line up with the state register.
    always_comb begin
        state_nx = state;
        presc_nx = (state == IDLE || tick) ? '0 : presc + PW'(1);
        dwell_nx = dwell_cnt;
        sweep_nx = sweep_cnt;
        lim_nx   = lim_q;
        led_nx   = led;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = UP;
                    led_nx   = '0;
                    presc_nx = '0;
                    sweep_nx = '0;
                    dwell_nx = '0;
                    lim_nx   = limit;
                end
            end
            UP: begin
                if (tick) begin
                    // >= rather than == keeps led from ever passing the top
                    if (led >= lim_q) begin
                        state_nx = HOLD_TOP;
                        dwell_nx = '0;
                    end else begin
                        led_nx = led + 8'd1;
                    end
                end
            end
            HOLD_TOP: begin
                if (tick) begin
                    if (dwell_cnt == DWELL_MAX) begin
                        state_nx = DOWN;
                        dwell_nx = '0;
                    end else begin
                        dwell_nx = dwell_cnt + 8'd1;
                    end
                end
            end
            DOWN: begin
                if (tick) begin
                    if (led == 8'd0) begin
                        sweep_nx = sweep_cnt + 32'd1;
                        if (CYCLES != 0 && sweep_nx == CYCLES) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = HOLD_BOT;
                            dwell_nx = '0;
                        end
                    end else begin
                        led_nx = led - 8'd1;
                    end
                end
            end
            HOLD_BOT: begin
                if (tick) begin
                    if (dwell_cnt == DWELL_MAX) begin
                        state_nx = UP;
                        dwell_nx = '0;
                    end else begin
                        dwell_nx = dwell_cnt + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort: stop wins over everything except reset once a sweep is running
        if (state != IDLE && stop) begin
            state_nx = IDLE;
            presc_nx = '0;
            led_nx   = led;
            done_nx  = 1'b0;
        end

        busy_nx = (state_nx != IDLE);
        dir_nx  = (state_nx == DOWN) || (state_nx == HOLD_TOP);
    end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb_led_sweep_ctrl: scoreboard bench; expected {led,busy,dir,done} tuples are
// queued with the cycle they are due and compared at the falling edge.
module tb_led_sweep_ctrl;

    localparam int DIV = 4, DWELL = 2, CYCLES = 2;

    logic       clk = 1'b0, srst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [7:0] limit = 8'd0;
    logic [7:0] led;
    logic       busy, dir, done;

    led_sweep_ctrl #(.DIV(DIV), .DWELL(DWELL), .CYCLES(CYCLES)) dut (
        .clk(clk), .srst(srst), .start(start), .stop(stop), .limit(limit),
        .led(led), .busy(busy), .dir(dir), .done(done)
    );

    always #5 clk = ~clk;

    // number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [7:0] l,
                             input logic b, input logic d, input logic dn);
        exp_t e;
        e.c = c; e.tag = tag; e.v = {l, b, d, dn};
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < c) chk("timeout", 32'(cyc), 32'(c));
    endtask

    // Pop every entry that has come due; a skipped entry is reported as late.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            if (e.c != cyc) chk({e.tag, "_late"}, 32'(cyc), 32'(e.c));
            else            chk(e.tag, {21'd0, led, busy, dir, done}, {21'd0, e.v});
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin : stim
        int e0;
        // reset state
        expect_at(1, "rst1", 8'd0, 0, 0, 0);
        expect_at(2, "rst2", 8'd0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        srst = 1'b0;

        // basic sweep, limit change ignored, start ignored, auto-stop
        e0 = cyc + 1;
        expect_at(e0,      "b_start",   8'd0, 1, 0, 0);
        expect_at(e0 + 3,  "b_pre",     8'd0, 1, 0, 0);
        expect_at(e0 + 4,  "b_l1",      8'd1, 1, 0, 0);
        expect_at(e0 + 8,  "b_l2",      8'd2, 1, 0, 0);
        expect_at(e0 + 12, "b_l3",      8'd3, 1, 0, 0);
        expect_at(e0 + 15, "b_up_end",  8'd3, 1, 0, 0);
        expect_at(e0 + 16, "b_htop",    8'd3, 1, 1, 0);
        expect_at(e0 + 27, "b_d_pre",   8'd3, 1, 1, 0);
        expect_at(e0 + 28, "b_d2",      8'd2, 1, 1, 0);
        expect_at(e0 + 32, "b_d1",      8'd1, 1, 1, 0);
        expect_at(e0 + 36, "b_d0",      8'd0, 1, 1, 0);
        expect_at(e0 + 39, "b_d0_hold", 8'd0, 1, 1, 0);
        expect_at(e0 + 40, "b_hbot",    8'd0, 1, 0, 0);
        expect_at(e0 + 52, "b_u1",      8'd1, 1, 0, 0);
        expect_at(e0 + 63, "lim_hold3", 8'd3, 1, 0, 0);
        expect_at(e0 + 64, "lim_top3",  8'd3, 1, 1, 0);
        expect_at(e0 + 87, "a_pre",     8'd0, 1, 1, 0);
        expect_at(e0 + 88, "auto_done", 8'd0, 0, 0, 1);
        expect_at(e0 + 89, "done_1cyc", 8'd0, 0, 0, 0);
        limit = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 20);
        limit = 8'd9;
        wait_until(e0 + 29);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 92);

        // abort in UP at led=2
        limit = 8'd3;
        e0 = cyc + 1;
        expect_at(e0,      "ab_start", 8'd0, 1, 0, 0);
        expect_at(e0 + 8,  "ab_l2",    8'd2, 1, 0, 0);
        expect_at(e0 + 9,  "ab_stop",  8'd2, 0, 0, 0);
        expect_at(e0 + 14, "ab_idle",  8'd2, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 8);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_until(e0 + 14);

        // restart from 0, then start+stop together in DOWN
        e0 = cyc + 1;
        expect_at(e0,      "rs_led0",   8'd0, 1, 0, 0);
        expect_at(e0 + 4,  "rs_l1",     8'd1, 1, 0, 0);
        expect_at(e0 + 25, "rs_down",   8'd3, 1, 1, 0);
        expect_at(e0 + 26, "race_ss",   8'd3, 0, 0, 0);
        expect_at(e0 + 30, "race_idle", 8'd3, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 25);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        wait_until(e0 + 30);

        // zero limit, accepted with stop also high in IDLE
        limit = 8'd0;
        e0 = cyc + 1;
        expect_at(e0,      "z_start",  8'd0, 1, 0, 0);
        expect_at(e0 + 3,  "z_pre",    8'd0, 1, 0, 0);
        expect_at(e0 + 4,  "z_htop",   8'd0, 1, 1, 0);
        expect_at(e0 + 15, "z_down",   8'd0, 1, 1, 0);
        expect_at(e0 + 16, "z_hbot",   8'd0, 1, 0, 0);
        expect_at(e0 + 27, "z_up2",    8'd0, 1, 0, 0);
        expect_at(e0 + 28, "z_htop2",  8'd0, 1, 1, 0);
        expect_at(e0 + 39, "z_down2",  8'd0, 1, 1, 0);
        expect_at(e0 + 40, "z_done",   8'd0, 0, 0, 1);
        expect_at(e0 + 41, "z_after",  8'd0, 0, 0, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        wait_until(e0 + 43);

        // reset in HOLD_TOP with start held
        limit = 8'd3;
        e0 = cyc + 1;
        expect_at(e0 + 16, "r_htop",      8'd3, 1, 1, 0);
        expect_at(e0 + 18, "r_reset",     8'd0, 0, 0, 0);
        expect_at(e0 + 19, "r_start_ign", 8'd0, 0, 0, 0);
        expect_at(e0 + 23, "r_idle",      8'd0, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 17);
        srst = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        srst = 1'b0; start = 1'b0;
        wait_until(e0 + 24);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
